// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA stage: walks i/j over the S memory, swaps in place and XORs the keystream with the ROM.
// Optional macro PRGA_VALID_CHECK_EN adds a per-byte plaintext check that aborts on a non-text byte.
module rc4_prga_decrypt #(
   parameter int MSG_LENGTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       finished,
   output logic       invalid,
   output logic [7:0] s_address,
   output logic [7:0] s_data,
   output logic       s_wen,
   input  logic [7:0] s_q,
   output logic [7:0] rom_address,
   input  logic [7:0] rom_q,
   output logic [7:0] ram_address,
   output logic [7:0] ram_data,
   output logic       ram_wen
);

   typedef enum logic [4:0] {
      ST_IDLE,
      ST_INC_I,
      ST_RD_SI_SET, ST_RD_SI_ACC, ST_RD_SI_WAIT,
      ST_UPD_J,
      ST_RD_SJ_SET, ST_RD_SJ_ACC, ST_RD_SJ_WAIT,
      ST_WR_SJ_SET, ST_WR_SJ_ACC, ST_WR_SJ_WAIT,
      ST_WR_SI_SET, ST_WR_SI_ACC, ST_WR_SI_WAIT,
      ST_RD_F_SET,  ST_RD_F_ACC,  ST_RD_F_WAIT,
      ST_WR_OUT_SET, ST_WR_OUT_ACC, ST_WR_OUT_WAIT,
      ST_CHECK,
      ST_DONE
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_i, r_j, r_k;
   logic [7:0] r_s_i, r_s_j, r_f, r_enc;
   logic [7:0] r_s_addr, r_s_dat, r_ram_addr, r_ram_dat;
   logic       r_finished;
   logic       w_last;
   logic       w_s_wen, w_ram_wen;

   assign w_last = (r_k == 8'(MSG_LENGTH - 1));

`ifdef PRGA_VALID_CHECK_EN
   logic r_invalid;
   logic w_char_ok;
   // Accept only space and lowercase letters; the byte under test is still on the RAM data bus.
   assign w_char_ok = (r_ram_dat == 8'h20) || ((r_ram_dat >= 8'h61) && (r_ram_dat <= 8'h7A));
   assign invalid   = r_invalid;
`else
   assign invalid   = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:        w_next = start ? ST_INC_I : ST_IDLE;
         ST_INC_I:       w_next = ST_RD_SI_SET;
         ST_RD_SI_SET:   w_next = ST_RD_SI_ACC;
         ST_RD_SI_ACC:   w_next = ST_RD_SI_WAIT;
         ST_RD_SI_WAIT:  w_next = ST_UPD_J;
         ST_UPD_J:       w_next = ST_RD_SJ_SET;
         ST_RD_SJ_SET:   w_next = ST_RD_SJ_ACC;
         ST_RD_SJ_ACC:   w_next = ST_RD_SJ_WAIT;
         ST_RD_SJ_WAIT:  w_next = ST_WR_SJ_SET;
         ST_WR_SJ_SET:   w_next = ST_WR_SJ_ACC;
         ST_WR_SJ_ACC:   w_next = ST_WR_SJ_WAIT;
         ST_WR_SJ_WAIT:  w_next = ST_WR_SI_SET;
         ST_WR_SI_SET:   w_next = ST_WR_SI_ACC;
         ST_WR_SI_ACC:   w_next = ST_WR_SI_WAIT;
         ST_WR_SI_WAIT:  w_next = ST_RD_F_SET;
         ST_RD_F_SET:    w_next = ST_RD_F_ACC;
         ST_RD_F_ACC:    w_next = ST_RD_F_WAIT;
         ST_RD_F_WAIT:   w_next = ST_WR_OUT_SET;
         ST_WR_OUT_SET:  w_next = ST_WR_OUT_ACC;
         ST_WR_OUT_ACC:  w_next = ST_WR_OUT_WAIT;
`ifdef PRGA_VALID_CHECK_EN
         ST_WR_OUT_WAIT: w_next = ST_CHECK;
         ST_CHECK:       w_next = (!w_char_ok || w_last) ? ST_DONE : ST_INC_I;
`else
         ST_WR_OUT_WAIT: w_next = w_last ? ST_DONE : ST_INC_I;
`endif
         ST_DONE:        w_next = ST_IDLE;
         default:        w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_s_wen   = 1'b0;
      w_ram_wen = 1'b0;
      case (r_state)
         ST_WR_SJ_ACC, ST_WR_SJ_WAIT,
         ST_WR_SI_ACC, ST_WR_SI_WAIT:   w_s_wen   = 1'b1;
         ST_WR_OUT_ACC, ST_WR_OUT_WAIT: w_ram_wen = 1'b1;
         default: ;
      endcase
   end

   // Addresses and write data load in the SET states; read data lands at the end of WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_i        <= 8'd0;
         r_j        <= 8'd0;
         r_k        <= 8'd0;
         r_s_i      <= 8'd0;
         r_s_j      <= 8'd0;
         r_f        <= 8'd0;
         r_enc      <= 8'd0;
         r_s_addr   <= 8'd0;
         r_s_dat    <= 8'd0;
         r_ram_addr <= 8'd0;
         r_ram_dat  <= 8'd0;
         r_finished <= 1'b0;
`ifdef PRGA_VALID_CHECK_EN
         r_invalid  <= 1'b0;
`endif
      end else begin
         r_finished <= (r_state == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_i <= 8'd0;
                  r_j <= 8'd0;
                  r_k <= 8'd0;
`ifdef PRGA_VALID_CHECK_EN
                  r_invalid <= 1'b0;
`endif
               end
            end
            ST_INC_I:      r_i <= r_i + 8'd1;
            ST_RD_SI_SET:  r_s_addr <= r_i;
            ST_RD_SI_WAIT: r_s_i <= s_q;
            ST_UPD_J:      r_j <= r_j + r_s_i;
            ST_RD_SJ_SET:  r_s_addr <= r_j;
            ST_RD_SJ_WAIT: r_s_j <= s_q;
            ST_WR_SJ_SET: begin
               r_s_addr <= r_j;
               r_s_dat  <= r_s_i;
            end
            ST_WR_SI_SET: begin
               r_s_addr <= r_i;
               r_s_dat  <= r_s_j;
            end
            ST_RD_F_SET:   r_s_addr <= r_s_i + r_s_j;
            ST_RD_F_WAIT: begin
               r_f   <= s_q;
               r_enc <= rom_q;
            end
            ST_WR_OUT_SET: begin
               r_ram_addr <= r_k;
               r_ram_dat  <= r_f ^ r_enc;
            end
`ifdef PRGA_VALID_CHECK_EN
            ST_CHECK: begin
               if (!w_char_ok)  r_invalid <= 1'b1;
               else if (!w_last) r_k <= r_k + 8'd1;
            end
`else
            ST_WR_OUT_WAIT: if (!w_last) r_k <= r_k + 8'd1;
`endif
            default: ;
         endcase
      end
   end

   assign finished    = r_finished;
   assign s_address   = r_s_addr;
   assign s_data      = r_s_dat;
   assign s_wen       = w_s_wen;
   assign rom_address = r_k;
   assign ram_address = r_ram_addr;
   assign ram_data    = r_ram_dat;
   assign ram_wen     = w_ram_wen;

endmodule
